shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//   Round-robin write arbiter for a W-bit shared storage register built from async-reset D flip-flops.
//   N requesters share the register. Each requester raises req and receives a one-cycle grant.
//   The register captures the granted requester's data on the edge that ends that grant cycle.
//   Sits between the lab datapath clients and the shared register bank; sole writer of that register.
// PARAMETERS
//   N  4  number of requesters (2..8; need not be a power of 2)
//   W  8  data width of the shared register
// PORTS
//   clk      in   1             rising-edge clock, the only clock
//   reset    in   1             asynchronous, active-low reset (0 = reset asserted)
//   req      in   N             req[i]=1: requester i wants to write
//   wdata    in   N*W           requester i data at wdata[i*W +: W]
//   clear    in   1             synchronous clear of q to 0
//   gnt      out  N             registered one-hot grant; high for exactly one cycle
//   q        out  W             shared register contents
//   wr_done  out  1             one-cycle pulse, high the cycle after the commit edge
//   owner    out  clog2(N)      index of the last committed writer (min width 1)
//   busy     out  1             1 while in GRANT state
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, gnt=0, q=0, wr_done=0, owner=0, rr pointer ptr=0.
//     Outputs clear immediately on reset, without waiting for a clock edge.
//   FSM states:
//     IDLE: on an edge with |req=1:
//       - winner = first i with req[i]=1, searching ptr, ptr+1, ... N-1, 0, ... (wraps).
//       - sel<=winner, gnt<=onehot(winner), state<=GRANT.
//       - If req==0, stay in IDLE with gnt=0.
//     GRANT: on the next edge:
//       - q<=wdata[sel*W +: W], owner<=sel, wr_done<=1, gnt<=0.
//       - ptr<=(sel==N-1)?0:sel+1, state<=IDLE.
//       - req is ignored in this state.
//   Latency: req sampled high in IDLE -> gnt high 1 cycle later -> q updated and wr_done high 2 cycles later.
//   Throughput: at most one commit every 2 cycles; GRANT always returns to IDLE.
//   Requester data rule: hold wdata stable while its gnt is high. Drop req in the gnt cycle;
//     a req still high at the following IDLE edge is a new request.
//   Committed grant: req dropping during GRANT does not cancel the write; the commit still occurs.
//   wr_done is high only in the cycle following the commit edge; otherwise 0.
//   clear=1 on any edge: q<=0. On a commit edge, clear takes priority for q, but owner, wr_done
//     and ptr still update as a normal commit.
//   Reset mid-GRANT: no commit; q=0, wr_done never pulses; ptr restarts at 0.
//   gnt is never multi-hot and never high two consecutive cycles. busy==(gnt!=0).
// TESTING
//   1 reset=0 for 3 cycles with random req -> gnt=0, q=0, wr_done=0, owner=0, busy=0 throughout.
//   2 req=4'b0001, wdata[7:0]=8'hA5 -> gnt=0001 at t+1; q=A5, wr_done=1, owner=0 at t+2.
//   3 req=4'b1111 held, data 10/11/12/13 -> gnts 0,1,2,3,0 every 2 cycles; q=10,11,12,13,10.
//   4 after grant to 2, req=4'b1001 -> grant 3 first, then 0 (pointer wraps).
//   5 reset=0 while gnt=0010 (data 8'h77) -> gnt=0 immediately, q stays 00, no wr_done;
//     after release, req=4'b0010 -> gnt=0010 (ptr restarted at 0).
//   6 clear=1 on the commit edge of requester 1 (data 8'h55) -> q=00, wr_done=1, owner=1.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for a shared W-bit register: one-cycle grants,
// commit on the edge ending the grant, rotating priority after each commit.
module shared_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int OW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  input  logic           clear,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           wr_done,
  output logic [OW-1:0]  owner,
  output logic           busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_r;
  logic [OW-1:0] sel_r;
  logic [OW-1:0] ptr_r;
  logic [OW-1:0] winner_s;
  logic [W-1:0]  data_s;

  // First requester at or after the pointer, wrapping at N (N need not be a power of 2).
  function automatic logic [OW-1:0] pick_winner(input logic [N-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = {OW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(p) + k;
      idx = (idx >= N) ? (idx - N) : idx;
      if (!found && r[idx[OW-1:0]]) begin
        found = 1'b1;
        pick  = idx[OW-1:0];
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [W-1:0] select_data(input logic [N*W-1:0] d, input logic [OW-1:0] s);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      r = (s == OW'(i)) ? d[i*W +: W] : r;
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] s);
    return (s == OW'(N - 1)) ? {OW{1'b0}} : (s + OW'(1));
  endfunction

  assign winner_s = pick_winner(req, ptr_r);
  assign data_s   = select_data(wdata, sel_r);

  // Arbitration FSM with registered grant, commit and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      sel_r   <= {OW{1'b0}};
      ptr_r   <= {OW{1'b0}};
      gnt     <= {N{1'b0}};
      q       <= {W{1'b0}};
      wr_done <= 1'b0;
      owner   <= {OW{1'b0}};
      busy    <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|req) begin
            sel_r   <= winner_s;
            gnt     <= {{(N-1){1'b0}}, 1'b1} << winner_s;
            busy    <= 1'b1;
            state_r <= GRANT;
          end else begin
            gnt     <= {N{1'b0}};
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        GRANT: begin
          // Requests are ignored here; the granted write commits regardless.
          owner   <= sel_r;
          wr_done <= 1'b1;
          gnt     <= {N{1'b0}};
          busy    <= 1'b0;
          ptr_r   <= next_ptr(sel_r);
          state_r <= IDLE;
        end
        default: begin
          gnt     <= {N{1'b0}};
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      // Clear wins over a commit for q only; owner/ptr/wr_done still update above.
      if (clear) begin
        q <= {W{1'b0}};
      end else if (state_r == GRANT) begin
        q <= data_s;
      end else begin
        q <= q;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: vector table plus hand-written
// sequences, all compared through an expected-value queue.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        clear;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        wr_done;
  logic [1:0]  owner;
  logic        busy;

  int total;
  int bad;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] q;
    logic       done;
    logic [1:0] owner;
    logic       busy;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  shared_reg_arbiter #(.N(4), .W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clear(clear),
    .gnt(gnt), .q(q), .wr_done(wr_done), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk_e(logic [3:0] g, logic [7:0] qq, logic d, logic [1:0] o, logic b);
    exp_t e;
    e.gnt = g; e.q = qq; e.done = d; e.owner = o; e.busy = b;
    return e;
  endfunction

  function automatic vec_t mk(string n, logic rs, logic [3:0] rq, logic [31:0] wd, logic cl,
                              logic [3:0] g, logic [7:0] qq, logic d, logic [1:0] o, logic b);
    vec_t v;
    v.name = n; v.rst = rs; v.req = rq; v.wdata = wd; v.clr = cl;
    v.e = mk_e(g, qq, d, o, b);
    return v;
  endfunction

  task automatic check(input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, required a queued expectation", name);
    end else begin
      e = sb.pop_front();
      if (gnt !== e.gnt || q !== e.q || wr_done !== e.done || owner !== e.owner || busy !== e.busy) begin
        bad++;
        $display("FAIL %s: got gnt=%b q=%h wr_done=%b owner=%0d busy=%b, expected gnt=%b q=%h wr_done=%b owner=%0d busy=%b",
                 name, gnt, q, wr_done, owner, busy, e.gnt, e.q, e.done, e.owner, e.busy);
      end
    end
    total++;
    if ((busy !== (gnt != 4'b0000)) || ($countones(gnt) > 1)) begin
      bad++;
      $display("FAIL %s_inv: got gnt=%b busy=%b, required one-hot-or-zero gnt and busy==(gnt!=0)",
               name, gnt, busy);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst;
    req   = v.req;
    wdata = v.wdata;
    clear = v.clr;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    check(v.name);
  endtask

  initial begin
    logic [7:0] pq;
    logic [1:0] po;
    int         j;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req   = 4'b0000;
    wdata = 32'h0000_0000;
    clear = 1'b0;

    // Reset held with random requests: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      apply(mk("reset_hold", 1'b0, 4'($urandom_range(0, 15)), $urandom, 1'b0,
               4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    end

    tbl.push_back(mk("single_gnt",   1'b1, 4'b0001, 32'h0000_00A5, 1'b0, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk("single_cmt",   1'b1, 4'b0000, 32'h0000_00A5, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk("idle_hold",    1'b1, 4'b0000, 32'h0000_00A5, 1'b0, 4'b0000, 8'hA5, 1'b0, 2'd0, 1'b0));
    tbl.push_back(mk("gnt2",         1'b1, 4'b0100, 32'h3322_1130, 1'b0, 4'b0100, 8'hA5, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk("cmt2_ignreq",  1'b1, 4'b1001, 32'h3322_1130, 1'b0, 4'b0000, 8'h22, 1'b1, 2'd2, 1'b0));
    tbl.push_back(mk("gnt3_first",   1'b1, 4'b1001, 32'h3322_1130, 1'b0, 4'b1000, 8'h22, 1'b0, 2'd2, 1'b1));
    tbl.push_back(mk("cmt3",         1'b1, 4'b1001, 32'h3322_1130, 1'b0, 4'b0000, 8'h33, 1'b1, 2'd3, 1'b0));
    tbl.push_back(mk("gnt0_wrap",    1'b1, 4'b1001, 32'h3322_1130, 1'b0, 4'b0001, 8'h33, 1'b0, 2'd3, 1'b1));
    tbl.push_back(mk("cmt0_wrap",    1'b1, 4'b0000, 32'h3322_1130, 1'b0, 4'b0000, 8'h30, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk("gnt1_clr",     1'b1, 4'b0010, 32'h0000_5500, 1'b0, 4'b0010, 8'h30, 1'b0, 2'd0, 1'b1));
    tbl.push_back(mk("cmt1_clear",   1'b1, 4'b0000, 32'h0000_5500, 1'b1, 4'b0000, 8'h00, 1'b1, 2'd1, 1'b0));
    tbl.push_back(mk("after_clear",  1'b1, 4'b0000, 32'h0000_5500, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd1, 1'b0));
    tbl.push_back(mk("ptr2_wrap_0",  1'b1, 4'b0011, 32'h0000_6677, 1'b0, 4'b0001, 8'h00, 1'b0, 2'd1, 1'b1));
    tbl.push_back(mk("cmt0_77",      1'b1, 4'b0000, 32'h0000_6677, 1'b0, 4'b0000, 8'h77, 1'b1, 2'd0, 1'b0));
    tbl.push_back(mk("idle_clear",   1'b1, 4'b0000, 32'h0000_6677, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset in the middle of a grant: outputs drop at once, no commit follows.
    apply(mk("pre_rst_gnt1", 1'b1, 4'b0010, 32'h0000_7700, 1'b0, 4'b0010, 8'h00, 1'b0, 2'd0, 1'b1));
    #2;
    reset = 1'b0;
    #1;
    sb.push_back(mk_e(4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    check("async_rst_now");
    apply(mk("rst_no_commit", 1'b0, 4'b0010, 32'h0000_7700, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    apply(mk("ptr_restart",   1'b1, 4'b0011, 32'h0000_7770, 1'b0, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b1));
    apply(mk("ptr_restart_c", 1'b1, 4'b0000, 32'h0000_7770, 1'b0, 4'b0000, 8'h70, 1'b1, 2'd0, 1'b0));

    // All four requesting continuously: grants rotate 0,1,2,3,0.
    apply(mk("rr_reset", 1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0));
    pq = 8'h00;
    po = 2'd0;
    for (int k = 0; k < 10; k++) begin
      j = (k / 2) % 4;
      if (k % 2 == 0) begin
        apply(mk("rr_gnt", 1'b1, 4'b1111, 32'h1312_1110, 1'b0, 4'(1 << j), pq, 1'b0, po, 1'b1));
      end else begin
        pq = 8'h10 + 8'(j);
        po = 2'(j);
        apply(mk("rr_cmt", 1'b1, 4'b1111, 32'h1312_1110, 1'b0, 4'b0000, pq, 1'b1, po, 1'b0));
      end
    end
    apply(mk("rr_idle", 1'b1, 4'b0000, 32'h1312_1110, 1'b0, 4'b0000, pq, 1'b0, po, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
